pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, flush-to-bubble and halt freeze. It replaces fixed-width, enable-only stage registers between any two pipeline stages, for example IF/ID, ID/EX or EX/MEM. It decouples upstream `in_ready` from downstream `out_ready` with no combinational path between them, and it counts back-pressure cycles for performance analysis.

## Interface
- `DATA_W`, 32: payload width (e.g. {pc, instruction}).
- `BUBBLE_VAL`, 32'h0000_4000: payload presented whenever the stage holds nothing (NOP encoding). Width is `DATA_W`.
- `CNT_W`, 16: width of the back-pressure counter.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `hlt` input 1: freeze; no transfer on either side while high.
- `flush` input 1: discard all held entries; the stage becomes empty.
- `in_valid` input 1: upstream has a payload.
- `in_ready` output 1: stage can accept a payload this cycle.
- `in_data` input `DATA_W`: upstream payload.
- `out_valid` output 1: stage presents a payload.
- `out_ready` input 1: downstream accepts this cycle.
- `out_data` output `DATA_W`: presented payload.
- `occ` output 2: entries held (0, 1 or 2).
- `bp_cnt` output `CNT_W`: back-pressure cycle count.

## Operation
- Storage is two entries: `main` (drives `out_data`) and `skid`. The state is encoded by occupancy:
  - EMPTY: `occ`=0.
  - ONE: `main` valid, `occ`=1.
  - FULL: `main` and `skid` valid, `occ`=2.
- Combinational handshake outputs:
  - `in_ready` = ~rst & ~flush & ~hlt & (state != FULL).
  - `out_valid` = main_valid & ~hlt & ~flush.
  - Consequently `in_ready` never depends on `out_ready`.
- Transfers:
  - push = `in_valid` & `in_ready`.
  - pop = `out_valid` & `out_ready`.
- Transitions (when neither `rst` nor `flush` is asserted):
  - EMPTY, push: go to ONE; `main` <= `in_data`.
  - ONE, push & pop: stay in ONE; `main` <= `in_data`.
  - ONE, push & ~pop: go to FULL; `skid` <= `in_data`.
  - ONE, ~push & pop: go to EMPTY; `main` <= `BUBBLE_VAL`.
  - FULL, pop: go to ONE; `main` <= `skid`. Push is impossible in FULL.
  - All other cases: hold.
- `out_data` equals `BUBBLE_VAL` whenever `main` is empty. The bubble value is stored in the register, not muxed at the output.
- Payloads leave in strict FIFO order. None is dropped or duplicated except by `flush`.
- `flush`:
  - On the next edge: go to EMPTY, `main` <= `BUBBLE_VAL`, `skid` invalidated.
  - A same-cycle input is not accepted, because `in_ready`=0.
  - `flush` beats `hlt` when both are asserted.
- `hlt` (without `flush`): all state holds; `in_ready`=0 and `out_valid`=0.
- `bp_cnt`:
  - Increments by 1 on each cycle with main_valid & ~hlt & ~flush & ~out_ready.
  - Saturates at 2^`CNT_W`-1; does not wrap.
  - Unaffected by `flush`; cleared only by `rst`.
- `rst`, applied at any time including mid-transfer:
  - Next edge: EMPTY, `main` = `BUBBLE_VAL`, skid invalid, `bp_cnt`=0.
  - While `rst` is high, `in_ready`=0 and `out_valid`=0.
  - `rst` has priority over `flush` and `hlt`.

## Timing
- Reset values: `out_valid`=0, `out_data`=`BUBBLE_VAL`, `occ`=0, `bp_cnt`=0. `in_ready`=1 on the first cycle after `rst` falls, provided `hlt`=`flush`=0.
- Latency: a push at edge N makes the payload visible on `out_data` with `out_valid`=1 after edge N; one cycle.
- Throughput: one payload per cycle sustained while `out_ready`=1.
- Back-pressure response:
  - A first stall in ONE absorbs one more push into `skid`.
  - `in_ready` falls the cycle after FULL is entered and rises the cycle after the first pop from FULL.
- All outputs are register-driven, except for AND-gating of `in_ready`/`out_valid` with `rst`/`hlt`/`flush`.

## Test plan
- **Reset.** Assert `rst` for 2 cycles mid-stream with `occ`=2 -> next cycle `occ`=0, `out_valid`=0, `out_data`=32'h0000_4000, `bp_cnt`=0. `in_ready`=1 the cycle after `rst` drops.
- **Streaming.** Push 0x11, 0x22, 0x33 on consecutive cycles with `out_ready`=1 -> `out_data` shows 0x11, 0x22, 0x33 one cycle later each. `occ` stays 1; `in_ready` is never low.
- **Skid fill/drain.**
  - Push 0xA1, then drop `out_ready` and push 0xA2 -> `occ`=2, `in_ready`=0, `bp_cnt` increments each stalled cycle.
  - Raise `out_ready` -> 0xA1 then 0xA2 are popped in order and `in_ready` returns to 1.
- **Flush.** With `occ`=2, assert `flush` alone, then `flush` with `hlt` -> `occ`=0, `out_valid`=0, `out_data`=`BUBBLE_VAL`. The `in_data` offered during the flush never appears at the output.
- **Halt.** With `occ`=1, assert `hlt` for 3 cycles with `in_valid`=`out_ready`=1 -> `in_ready`=0, `out_valid`=0, state and `bp_cnt` unchanged. The held payload pops on the first cycle after `hlt` drops.
- **Saturation.** With `CNT_W`=4, hold `out_ready`=0 for 20 cycles -> `bp_cnt` stops at 15.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer; one-cycle latency, full throughput.
// in_ready comes from local occupancy only, so back-pressure never forms a combinational path.
module pipe_stage_skid #(
   parameter int unsigned       DATA_W     = 32,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(32'h0000_4000),
   parameter int unsigned       CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hlt,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occ,
   output logic [CNT_W-1:0]  bp_cnt
);

   localparam logic [1:0]       OCC_EMPTY = 2'd0;
   localparam logic [1:0]       OCC_ONE   = 2'd1;
   localparam logic [1:0]       OCC_FULL  = 2'd2;
   localparam logic [CNT_W-1:0] BP_MAX    = '1;

   logic [1:0]        occ_q, occ_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic [CNT_W-1:0]  bp_cnt_q, bp_cnt_d;

   logic main_vld;
   logic push;
   logic pop;
   logic bp_inc;

   assign main_vld  = (occ_q != OCC_EMPTY);
   assign in_ready  = ~rst & ~flush & ~hlt & (occ_q != OCC_FULL);
   assign out_valid = ~rst & ~flush & ~hlt & main_vld;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign bp_inc    = main_vld & ~hlt & ~flush & ~out_ready;

   assign out_data = main_q;
   assign occ      = occ_q;
   assign bp_cnt   = bp_cnt_q;

   always_comb begin
      occ_d    = occ_q;
      main_d   = main_q;
      skid_d   = skid_q;
      bp_cnt_d = bp_cnt_q;

      if (bp_inc && (bp_cnt_q != BP_MAX)) begin
         bp_cnt_d = bp_cnt_q + CNT_W'(1);
      end

      // Empty main always carries the bubble so out_data needs no output mux.
      if (flush) begin
         occ_d  = OCC_EMPTY;
         main_d = BUBBLE_VAL;
      end else begin
         case (occ_q)
            OCC_EMPTY: begin
               if (push) begin
                  occ_d  = OCC_ONE;
                  main_d = in_data;
               end
            end
            OCC_ONE: begin
               if (push && pop) begin
                  main_d = in_data;
               end else if (push) begin
                  occ_d  = OCC_FULL;
                  skid_d = in_data;
               end else if (pop) begin
                  occ_d  = OCC_EMPTY;
                  main_d = BUBBLE_VAL;
               end
            end
            OCC_FULL: begin
               if (pop) begin
                  occ_d  = OCC_ONE;
                  main_d = skid_q;
               end
            end
            default: begin
               occ_d  = OCC_EMPTY;
               main_d = BUBBLE_VAL;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q    <= OCC_EMPTY;
         main_q   <= BUBBLE_VAL;
         skid_q   <= BUBBLE_VAL;
         bp_cnt_q <= '0;
      end else begin
         occ_q    <= occ_d;
         main_q   <= main_d;
         skid_q   <= skid_d;
         bp_cnt_q <= bp_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_stage_skid;

   localparam logic [31:0] BUB = 32'h0000_4000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hlt = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_data = '0;

   logic        in_ready, out_valid;
   logic [31:0] out_data;
   logic [1:0]  occ;
   logic [15:0] bp_cnt;

   logic        in_ready4, out_valid4;
   logic [31:0] out_data4;
   logic [1:0]  occ4;
   logic [3:0]  bp_cnt4;

   int checks = 0;
   int errors = 0;

   // Reference model: ordered list of held payloads plus ideal stall counters.
   logic [31:0] mq[$];
   int          mbp  = 0;
   int          mbp4 = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(32), .BUBBLE_VAL(BUB), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .hlt(hlt), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occ(occ), .bp_cnt(bp_cnt)
   );

   pipe_stage_skid #(.DATA_W(32), .BUBBLE_VAL(BUB), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .hlt(hlt), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
      .occ(occ4), .bp_cnt(bp_cnt4)
   );

   function automatic logic e_in_ready();
      return !rst && !flush && !hlt && (mq.size() < 2);
   endfunction

   function automatic logic e_out_valid();
      return !rst && !flush && !hlt && (mq.size() > 0);
   endfunction

   function automatic logic [31:0] e_out_data();
      return (mq.size() > 0) ? mq[0] : BUB;
   endfunction

   task automatic tick();
      int          sz;
      logic        pu, po, st;
      logic [31:0] d;
      sz = mq.size();
      pu = in_valid && e_in_ready();
      po = e_out_valid() && out_ready;
      st = (sz > 0) && !rst && !hlt && !flush && !out_ready;
      d  = in_data;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         mbp  = 0;
         mbp4 = 0;
      end else begin
         if (st) begin
            if (mbp < 65535) mbp++;
            if (mbp4 < 15) mbp4++;
         end
         if (flush) begin
            mq.delete();
         end else begin
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back(d);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; hlt = 1'b0; flush = 1'b0;
      tick(); tick(); #2;
      checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occ); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== BUB) begin errors++; $display("FAIL reset_out_data got %h exp %h", out_data, BUB); end
      checks++; if (bp_cnt !== 16'd0) begin errors++; $display("FAIL reset_bp_cnt got %0d exp 0", bp_cnt); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during got %b exp 0", in_ready); end
      rst = 1'b0; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got %b exp 1", in_ready); end
   endtask

   task automatic test_streaming();
      logic [31:0] v[3];
      v[0] = 32'h11; v[1] = 32'h22; v[2] = 32'h33;
      out_ready = 1'b1; in_valid = 1'b1; in_data = v[0]; #2;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready0 got %b exp 1", in_ready); end
      tick();
      for (int i = 1; i <= 3; i++) begin
         if (i < 3) in_data = v[i];
         else in_valid = 1'b0;
         #2;
         checks++; if (out_data !== v[i-1]) begin errors++; $display("FAIL stream_data%0d got %h exp %h", i, out_data, v[i-1]); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid%0d got %b exp 1", i, out_valid); end
         checks++; if (occ !== 2'd1) begin errors++; $display("FAIL stream_occ%0d got %0d exp 1", i, occ); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready%0d got %b exp 1", i, in_ready); end
         tick();
      end
      #2;
      checks++; if (out_data !== BUB) begin errors++; $display("FAIL stream_drain got %h exp %h", out_data, BUB); end
   endtask

   task automatic test_skid();
      int b0;
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA1; #2;
      tick();
      out_ready = 1'b0; in_data = 32'hA2; #2;
      b0 = mbp;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_absorb_ready got %b exp 1", in_ready); end
      checks++; if (out_data !== 32'hA1) begin errors++; $display("FAIL skid_head got %h exp a1", out_data); end
      checks++; if (bp_cnt !== 16'(b0)) begin errors++; $display("FAIL skid_bp0 got %0d exp %0d", bp_cnt, b0); end
      tick();
      in_valid = 1'b0; #2;
      checks++; if (occ !== 2'd2) begin errors++; $display("FAIL skid_full_occ got %0d exp 2", occ); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_full_ready got %b exp 0", in_ready); end
      checks++; if (bp_cnt !== 16'(b0 + 1)) begin errors++; $display("FAIL skid_bp1 got %0d exp %0d", bp_cnt, b0 + 1); end
      tick(); #2;
      checks++; if (bp_cnt !== 16'(b0 + 2)) begin errors++; $display("FAIL skid_bp2 got %0d exp %0d", bp_cnt, b0 + 2); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_still_full got %b exp 0", in_ready); end
      out_ready = 1'b1;
      checks++; if (out_data !== 32'hA1 || out_valid !== 1'b1) begin errors++; $display("FAIL skid_pop1 got %h/%b exp a1/1", out_data, out_valid); end
      tick(); #2;
      checks++; if (out_data !== 32'hA2) begin errors++; $display("FAIL skid_pop2 got %h exp a2", out_data); end
      checks++; if (in_ready !== 1'b1 || occ !== 2'd1) begin errors++; $display("FAIL skid_reopen got ready %b occ %0d exp 1/1", in_ready, occ); end
      tick(); #2;
      checks++; if (occ !== 2'd0 || out_data !== BUB) begin errors++; $display("FAIL skid_empty got occ %0d data %h exp 0/%h", occ, out_data, BUB); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hB1; #2;
      tick();
      in_data = 32'hB2; tick(); #2;
      checks++; if (occ !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got %0d exp 2", occ); end
      flush = 1'b1; in_data = 32'hDEAD_0001; #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_gating got %b/%b exp 0/0", in_ready, out_valid); end
      tick();
      flush = 1'b0; in_valid = 1'b0; #2;
      checks++; if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== BUB) begin errors++; $display("FAIL flush_alone got occ %0d vld %b data %h", occ, out_valid, out_data); end
      in_valid = 1'b1; in_data = 32'hC1; tick();
      in_data = 32'hC2; tick(); #2;
      checks++; if (occ !== 2'd2) begin errors++; $display("FAIL flush_refill_occ got %0d exp 2", occ); end
      flush = 1'b1; hlt = 1'b1; in_data = 32'hDEAD_0002; #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_hlt_gating got %b/%b exp 0/0", in_ready, out_valid); end
      tick();
      flush = 1'b0; hlt = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #2;
      checks++; if (occ !== 2'd0 || out_data !== BUB) begin errors++; $display("FAIL flush_hlt got occ %0d data %h", occ, out_data); end
      tick(); #2;
      checks++; if (out_valid !== 1'b0 || out_data !== BUB) begin errors++; $display("FAIL flush_no_leak got %b/%h", out_valid, out_data); end
   endtask

   task automatic test_halt();
      int b0;
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hD1; #2;
      tick();
      in_data = 32'hD2; hlt = 1'b1; b0 = mbp;
      for (int i = 0; i < 3; i++) begin
         #2;
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL halt_gating%0d got %b/%b exp 0/0", i, in_ready, out_valid); end
         checks++; if (occ !== 2'd1 || out_data !== 32'hD1) begin errors++; $display("FAIL halt_hold%0d got occ %0d data %h", i, occ, out_data); end
         checks++; if (bp_cnt !== 16'(b0)) begin errors++; $display("FAIL halt_bp%0d got %0d exp %0d", i, bp_cnt, b0); end
         tick();
      end
      hlt = 1'b0; in_valid = 1'b0; #2;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hD1) begin errors++; $display("FAIL halt_release got %b/%h exp 1/d1", out_valid, out_data); end
      tick(); #2;
      checks++; if (occ !== 2'd0) begin errors++; $display("FAIL halt_popped got %0d exp 0", occ); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 99) < 20 + (i % 150) / 2);
         hlt       = ($urandom_range(0, 9) == 0);
         flush     = ($urandom_range(0, 24) == 0);
         in_data   = $urandom();
         #2;
         checks++; if (in_ready !== e_in_ready()) begin errors++; $display("FAIL rnd_in_ready c%0d got %b exp %b", i, in_ready, e_in_ready()); end
         checks++; if (out_valid !== e_out_valid()) begin errors++; $display("FAIL rnd_out_valid c%0d got %b exp %b", i, out_valid, e_out_valid()); end
         checks++; if (out_data !== e_out_data()) begin errors++; $display("FAIL rnd_out_data c%0d got %h exp %h", i, out_data, e_out_data()); end
         checks++; if (occ !== 2'(mq.size())) begin errors++; $display("FAIL rnd_occ c%0d got %0d exp %0d", i, occ, mq.size()); end
         checks++; if (bp_cnt !== 16'(mbp)) begin errors++; $display("FAIL rnd_bp c%0d got %0d exp %0d", i, bp_cnt, mbp); end
         checks++; if (bp_cnt4 !== 4'(mbp4)) begin errors++; $display("FAIL rnd_bp4 c%0d got %0d exp %0d", i, bp_cnt4, mbp4); end
         checks++; if (in_ready4 !== e_in_ready() || out_valid4 !== e_out_valid()) begin errors++; $display("FAIL rnd_hs4 c%0d got %b/%b", i, in_ready4, out_valid4); end
         checks++; if (out_data4 !== e_out_data() || occ4 !== 2'(mq.size())) begin errors++; $display("FAIL rnd_dat4 c%0d got %h/%0d", i, out_data4, occ4); end
         tick();
      end
      in_valid = 1'b0; hlt = 1'b0; flush = 1'b0;
   endtask

   task automatic test_saturation();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; hlt = 1'b0; flush = 1'b0;
      tick();
      rst = 1'b0; in_valid = 1'b1; in_data = 32'h5A; tick();
      in_valid = 1'b0;
      for (int n = 0; n < 20; n++) begin
         #2;
         checks++; if (bp_cnt4 !== 4'((n < 15) ? n : 15)) begin errors++; $display("FAIL sat_step%0d got %0d exp %0d", n, bp_cnt4, (n < 15) ? n : 15); end
         tick();
      end
      #2;
      checks++; if (bp_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cap got %0d exp 15", bp_cnt4); end
      checks++; if (bp_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide got %0d exp 20", bp_cnt); end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hE1; tick(); #2;
      checks++; if (occ !== 2'd2) begin errors++; $display("FAIL rstmid_pre_occ got %0d exp 2", occ); end
      rst = 1'b1; out_ready = 1'b1; in_data = 32'hE2; #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_gating got %b/%b exp 0/0", in_ready, out_valid); end
      tick(); tick();
      rst = 1'b0; in_valid = 1'b0; #2;
      checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state got occ %0d vld %b", occ, out_valid); end
      checks++; if (out_data !== BUB || bp_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_regs got %h/%0d exp %h/0", out_data, bp_cnt, BUB); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", in_ready); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_skid();
      test_flush();
      test_halt();
      test_random();
      test_saturation();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
